// File: rtl/config_pkg.sv
// Shared core-configuration types used to parameterise CVA6 front-end blocks.
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned NrCommitPorts;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/decode_issue_buffer.sv
// Small first-word-fall-through queue between decode and issue that holds at
// most one control-flow instruction and remembers the last issued entry.
module decode_issue_buffer #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter type scoreboard_entry_t = logic,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  scoreboard_entry_t          decoded_instr_i,
    input  logic [31:0]                orig_instr_i,
    input  logic                       is_ctrl_flow_i,
    input  logic                       decoded_instr_valid_i,
    output logic                       decoded_instr_ready_o,
    output scoreboard_entry_t          issue_instr_o,
    output scoreboard_entry_t          issue_instr_prev_o,
    output logic [31:0]                orig_instr_o,
    output logic                       is_ctrl_flow_o,
    output logic                       issue_instr_valid_o,
    input  logic                       issue_instr_ack_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    scoreboard_entry_t  instr_mem [DEPTH];
    logic [31:0]        orig_mem  [DEPTH];
    logic               ctrl_mem  [DEPTH];

    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               ctrl_pending;
    scoreboard_entry_t  prev_instr;

    logic               enq;
    logic               deq;
    logic               head_valid;

    assign head_valid            = (count != '0);
    assign decoded_instr_ready_o = (count < CNT_W'(DEPTH)) && !ctrl_pending;
    assign enq                   = decoded_instr_valid_i && decoded_instr_ready_o && !flush_i;
    assign deq                   = head_valid && issue_instr_ack_i && !flush_i;

    // Head is read straight from storage; an empty buffer presents all zeros.
    assign issue_instr_valid_o = head_valid;
    assign issue_instr_o       = head_valid ? instr_mem[rd_ptr] : '0;
    assign orig_instr_o        = head_valid ? orig_mem[rd_ptr]  : '0;
    assign is_ctrl_flow_o      = head_valid ? ctrl_mem[rd_ptr]  : 1'b0;
    assign issue_instr_prev_o  = prev_instr;
    assign count_o             = count;

    always_ff @(posedge clk_i) begin
        if (enq) begin
            instr_mem[wr_ptr] <= decoded_instr_i;
            orig_mem[wr_ptr]  <= orig_instr_i;
            ctrl_mem[wr_ptr]  <= is_ctrl_flow_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            ctrl_pending <= 1'b0;
            prev_instr   <= '0;
        end else if (flush_i) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            ctrl_pending <= 1'b0;
            prev_instr   <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                prev_instr <= instr_mem[rd_ptr];
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Enqueue of a new branch is blocked while one is held, so set and clear never collide.
            if (deq && ctrl_mem[rd_ptr]) begin
                ctrl_pending <= 1'b0;
            end
            if (enq && is_ctrl_flow_i) begin
                ctrl_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Directed scoreboard bench for decode_issue_buffer at DEPTH=2 and DEPTH=4.
module tb_decode_issue_buffer;

    typedef struct packed {
        logic [15:0] instr;
        logic [31:0] orig;
        logic        ctrl;
    } entry_t;

    logic clk;
    logic rst_n;

    // Instance A: DEPTH = 2
    logic        flush_a, ctrl_a, valid_a, ack_a;
    logic [15:0] instr_a;
    logic [31:0] orig_a;
    logic        ready_a, ctrlo_a, valido_a;
    logic [15:0] issue_a, prev_a;
    logic [31:0] origo_a;
    logic [1:0]  count_a;

    // Instance B: DEPTH = 4
    logic        flush_b, ctrl_b, valid_b, ack_b;
    logic [15:0] instr_b;
    logic [31:0] orig_b;
    logic        ready_b, ctrlo_b, valido_b;
    logic [15:0] issue_b, prev_b;
    logic [31:0] origo_b;
    logic [2:0]  count_b;

    entry_t qa[$];
    entry_t qb[$];
    entry_t exp_e;
    int     vectors;
    int     miscompares;

    decode_issue_buffer #(.scoreboard_entry_t(logic [15:0]), .DEPTH(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_a),
        .decoded_instr_i(instr_a), .orig_instr_i(orig_a), .is_ctrl_flow_i(ctrl_a),
        .decoded_instr_valid_i(valid_a), .decoded_instr_ready_o(ready_a),
        .issue_instr_o(issue_a), .issue_instr_prev_o(prev_a), .orig_instr_o(origo_a),
        .is_ctrl_flow_o(ctrlo_a), .issue_instr_valid_o(valido_a),
        .issue_instr_ack_i(ack_a), .count_o(count_a)
    );

    decode_issue_buffer #(.scoreboard_entry_t(logic [15:0]), .DEPTH(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_b),
        .decoded_instr_i(instr_b), .orig_instr_i(orig_b), .is_ctrl_flow_i(ctrl_b),
        .decoded_instr_valid_i(valid_b), .decoded_instr_ready_o(ready_b),
        .issue_instr_o(issue_b), .issue_instr_prev_o(prev_b), .orig_instr_o(origo_b),
        .is_ctrl_flow_o(ctrlo_b), .issue_instr_valid_o(valido_b),
        .issue_instr_ack_i(ack_b), .count_o(count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulusA(input logic v, input logic [15:0] ins, input logic c, input logic a);
        valid_a = v;
        instr_a = ins;
        orig_a  = {16'hC0DE, ins};
        ctrl_a  = c;
        ack_a   = a;
    endtask

    task automatic checkHeadA(input string tag, input entry_t e);
        checkOutput({tag, "_instr"}, 64'(issue_a), 64'(e.instr));
        checkOutput({tag, "_orig"},  64'(origo_a), 64'(e.orig));
        checkOutput({tag, "_ctrl"},  64'(ctrlo_a), 64'(e.ctrl));
    endtask

    initial begin
        int sent;
        int got;
        int cyc;
        logic a_now;
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        flush_a = 1'b0; flush_b = 1'b0;
        applyStimulusA(1'b0, 16'h0, 1'b0, 1'b0);
        valid_b = 1'b0; instr_b = '0; orig_b = '0; ctrl_b = 1'b0; ack_b = 1'b0;

        // Reset state
        #3;
        checkOutput("rst_count_a", 64'(count_a), 64'd0);
        checkOutput("rst_valid_a", 64'(valido_a), 64'd0);
        checkOutput("rst_count_b", 64'(count_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_ready_a", 64'(ready_a), 64'd1);
        checkOutput("rst_prev_a", 64'(prev_a), 64'd0);

        // Fill A then B with no ack
        applyStimulusA(1'b1, 16'hA001, 1'b0, 1'b0);
        qa.push_back({instr_a, orig_a, ctrl_a});
        tick();
        checkOutput("fill_count1", 64'(count_a), 64'd1);
        checkOutput("fill_valid1", 64'(valido_a), 64'd1);
        checkHeadA("fill_head1", qa[0]);
        applyStimulusA(1'b1, 16'hB002, 1'b0, 1'b0);
        qa.push_back({instr_a, orig_a, ctrl_a});
        tick();
        checkOutput("fill_count2", 64'(count_a), 64'd2);
        checkOutput("fill_ready_full", 64'(ready_a), 64'd0);
        checkHeadA("fill_head2", qa[0]);
        applyStimulusA(1'b0, 16'h0, 1'b0, 1'b1);
        exp_e = qa.pop_front();
        tick();
        checkOutput("fill_prev_a", 64'(prev_a), 64'(exp_e.instr));
        checkHeadA("fill_head_b", qa[0]);
        exp_e = qa.pop_front();
        tick();
        checkOutput("drain_prev_b", 64'(prev_a), 64'(exp_e.instr));
        checkOutput("drain_valid", 64'(valido_a), 64'd0);
        checkOutput("drain_issue_zero", 64'(issue_a), 64'd0);
        checkOutput("drain_orig_zero", 64'(origo_a), 64'd0);

        // Control-flow entry blocks further enqueue
        applyStimulusA(1'b1, 16'h3333, 1'b1, 1'b0);
        qa.push_back({instr_a, orig_a, ctrl_a});
        tick();
        checkOutput("ctrl_ready", 64'(ready_a), 64'd0);
        checkOutput("ctrl_count", 64'(count_a), 64'd1);
        checkHeadA("ctrl_head", qa[0]);
        applyStimulusA(1'b1, 16'h4444, 1'b0, 1'b0);
        tick();
        checkOutput("ctrl_hold_count", 64'(count_a), 64'd1);
        applyStimulusA(1'b0, 16'h0, 1'b0, 1'b1);
        exp_e = qa.pop_front();
        tick();
        checkOutput("ctrl_ack_ready", 64'(ready_a), 64'd1);
        checkOutput("ctrl_ack_prev", 64'(prev_a), 64'(exp_e.instr));
        checkOutput("ctrl_ack_count", 64'(count_a), 64'd0);

        // Ack on an empty buffer is ignored
        tick();
        checkOutput("empty_ack_count", 64'(count_a), 64'd0);
        checkOutput("empty_ack_prev", 64'(prev_a), 64'(exp_e.instr));

        // Simultaneous enqueue and dequeue
        applyStimulusA(1'b1, 16'h5A5A, 1'b0, 1'b0);
        qa.push_back({instr_a, orig_a, ctrl_a});
        tick();
        applyStimulusA(1'b1, 16'h6B6B, 1'b0, 1'b1);
        qa.push_back({instr_a, orig_a, ctrl_a});
        exp_e = qa.pop_front();
        tick();
        checkOutput("simul_count", 64'(count_a), 64'd1);
        checkOutput("simul_prev", 64'(prev_a), 64'(exp_e.instr));
        checkHeadA("simul_head", qa[0]);

        // Flush at count 2 with valid and ack both high
        applyStimulusA(1'b1, 16'h7C7C, 1'b0, 1'b0);
        qa.push_back({instr_a, orig_a, ctrl_a});
        tick();
        checkOutput("pre_flush_count", 64'(count_a), 64'd2);
        flush_a = 1'b1;
        applyStimulusA(1'b1, 16'h8D8D, 1'b0, 1'b1);
        qa.delete();
        tick();
        flush_a = 1'b0;
        applyStimulusA(1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("flush_count", 64'(count_a), 64'd0);
        checkOutput("flush_valid", 64'(valido_a), 64'd0);
        checkOutput("flush_prev", 64'(prev_a), 64'd0);
        checkOutput("flush_ready", 64'(ready_a), 64'd1);
        tick();
        checkOutput("flush_not_stored", 64'(count_a), 64'd0);

        // Wrap: stream 10 entries through DEPTH=4 with random ack
        sent = 0;
        got  = 0;
        for (cyc = 0; cyc < 300 && got < 10; cyc++) begin
            valid_b = (sent < 10);
            instr_b = 16'h1000 + 16'(sent);
            orig_b  = 32'hFACE_0000 + 32'(sent * 3);
            ctrl_b  = 1'b0;
            a_now   = 1'($urandom_range(0, 1));
            ack_b   = a_now;
            if (valid_b && ready_b) begin
                qb.push_back({instr_b, orig_b, ctrl_b});
                sent++;
            end
            if (valido_b && a_now) begin
                if (qb.size() == 0) begin
                    checkOutput("wrap_spurious_valid", 64'(valido_b), 64'd0);
                end else begin
                    exp_e = qb.pop_front();
                    checkOutput("wrap_order_instr", 64'(issue_b), 64'(exp_e.instr));
                    checkOutput("wrap_order_orig", 64'(origo_b), 64'(exp_e.orig));
                    got++;
                end
            end
            tick();
            checkOutput("wrap_count_bound", 64'(count_b <= 3'd4), 64'd1);
        end
        valid_b = 1'b0;
        ack_b   = 1'b0;
        checkOutput("wrap_all_received", 64'(got), 64'd10);
        checkOutput("wrap_final_count", 64'(count_b), 64'd0);

        // Reset mid-operation at count 3
        for (int i = 0; i < 3; i++) begin
            valid_b = 1'b1;
            instr_b = 16'h2000 + 16'(i);
            orig_b  = 32'(i);
            tick();
        end
        valid_b = 1'b0;
        checkOutput("pre_reset_count", 64'(count_b), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_valid", 64'(valido_b), 64'd0);
        checkOutput("reset_count", 64'(count_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_ready", 64'(ready_b), 64'd1);
        checkOutput("reset_prev", 64'(prev_b), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_issue_buffer.md
DECODE_ISSUE_BUFFER -- requirements
Module: decode_issue_buffer

Interface
REQ-001 Parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, core configuration.
REQ-002 Parameter scoreboard_entry_t, default logic, decoded instruction type.
REQ-003 Parameter DEPTH, default 2, buffer entries (power of two, 2..8).
REQ-004 One clock; reset is asynchronous and active-low: clk_i input 1, rising-edge clock.
REQ-005 rst_ni input 1, asynchronous active-low reset.
REQ-006 flush_i input 1, discard all buffered entries.
REQ-007 decoded_instr_i input scoreboard_entry_t, entry from decoder.
REQ-008 orig_instr_i input 32, raw instruction word.
REQ-009 is_ctrl_flow_i input 1, entry is a control-flow instruction.
REQ-010 decoded_instr_valid_i input 1, decoder offers an entry.
REQ-011 decoded_instr_ready_o output 1, buffer accepts the entry.
REQ-012 issue_instr_o output scoreboard_entry_t, head entry to issue stage.
REQ-013 issue_instr_prev_o output scoreboard_entry_t, last entry acknowledged by issue stage.
REQ-014 orig_instr_o output 32, head raw instruction.
REQ-015 is_ctrl_flow_o output 1, head control-flow flag.
REQ-016 issue_instr_valid_o output 1, head is valid.
REQ-017 issue_instr_ack_i input 1, issue stage consumed head.
REQ-018 count_o output $clog2(DEPTH)+1, current occupancy.

Function
REQ-019 Enqueue occurs when decoded_instr_valid_i && decoded_instr_ready_o && !flush_i.
REQ-020 Dequeue occurs when issue_instr_valid_o && issue_instr_ack_i && !flush_i.
REQ-021 First-word fall-through: head outputs reflect the oldest entry combinationally from storage; no input-to-output bypass, so enqueue-to-valid latency is exactly 1 cycle.
REQ-022 issue_instr_valid_o = (count != 0); with count == 0, issue_instr_o, orig_instr_o and is_ctrl_flow_o are '0.
REQ-023 decoded_instr_ready_o = (count < DEPTH) && !ctrl_pending; it does not depend on issue_instr_ack_i.
REQ-024 ctrl_pending is set on enqueue of an entry with is_ctrl_flow_i=1; it is cleared on dequeue of the entry with is_ctrl_flow=1; at most one control-flow entry is held.
REQ-025 Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
REQ-026 Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-027 Ack with issue_instr_valid_o=0 is ignored; valid_i while not ready is ignored and the decoder must hold.
REQ-028 On each dequeue, issue_instr_prev_o is loaded with the dequeued entry one cycle later and held until the next dequeue.
REQ-029 flush_i: next cycle count=0, pointers=0, ctrl_pending=0, issue_instr_prev_o='0; same-cycle enqueue and dequeue are dropped.
REQ-030 Storage contents need not be cleared on flush; only valid state is observable.

Reset
REQ-031 On rst_ni low, asynchronously: count_o=0, pointers=0, ctrl_pending=0, issue_instr_prev_o='0, issue_instr_valid_o=0, decoded_instr_ready_o=1 once rst_ni is high.
REQ-032 Reset mid-operation discards all entries with no partial outputs.

Structure
REQ-033 scoreboard_entry_t comes from the shared ariane_pkg/CVA6Cfg-derived types; no new package types are needed.
REQ-034 DEPTH stays a local parameter of the module; no shared constant is needed.
REQ-035 A single flat module holds entry storage, pointers, counter, the ctrl_pending flag and the prev register; no sub-module.

Verification
REQ-036 Fill: DEPTH=2, enqueue A, B with no ack -> ready_o low at count 2; head=A; ack -> head=B, prev=A next cycle.
REQ-037 Control flow: enqueue branch J (is_ctrl_flow_i=1) -> ready_o=0 next cycle with count=1; ack J -> ready_o=1 and prev=J.
REQ-038 Simultaneous: count=1 (A), enqueue B with ack -> count stays 1, head=B, prev=A.
REQ-039 Flush: count=2, flush_i together with valid_i=1 and ack=1 -> next cycle count=0, valid_o=0, prev='0, entry not stored.
REQ-040 Wrap: DEPTH=4, stream 10 entries with random ack -> output order is identical to input order and count_o never exceeds 4.
REQ-041 Reset: assert rst_ni low while count=3 -> immediately valid_o=0 and count_o=0; after release ready_o=1.
